// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional busy watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [$clog2(NUM_REQ)-1:0]   active_id,
  output logic                         busy,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         tx_en,
  input  logic                         tx_busy,
  output logic                         timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_ACK
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_q;
  logic [ID_W-1:0]     active_id_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_en_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                busy_q;
  logic                win_valid_d;
  logic [ID_W-1:0]     win_id_d;
  int                  pick_idx;
  logic                tmo_hit;

  if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 4) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  // Search starts just after the last served requester and wraps.
  always_comb begin
    win_valid_d = 1'b0;
    win_id_d    = '0;
    pick_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pick_idx = (int'(last_q) + k) % NUM_REQ;
      if (!win_valid_d && req[pick_idx]) begin
        win_valid_d = 1'b1;
        win_id_d    = ID_W'(pick_idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  assign tmo_hit = in_wait && (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

  // Cleared in LAUNCH so it reads 0 in the first WAIT_BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (state_q == S_LAUNCH)
        cnt_q <= '0;
      else if (in_wait)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      active_id_q <= '0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      grant_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_valid_d) begin
            active_id_q <= win_id_d;
            tx_data_q   <= req_data[win_id_d*DATA_W +: DATA_W];
            tx_en_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (tmo_hit) begin
            grant_q <= ONE_HOT0 << active_id_q;
            state_q <= S_ACK;
          end else if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tmo_hit || !tx_busy) begin
            grant_q <= ONE_HOT0 << active_id_q;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          last_q  <= active_id_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign active_id = active_id_q;
  assign busy      = busy_q;
  assign tx_data   = tx_data_q;
  assign tx_en     = tx_en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [1:0]     active_id;
  logic           busy;
  logic [W-1:0]   tx_data;
  logic           tx_en;
  logic           tx_busy;
  logic           timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .active_id(active_id), .busy(busy), .tx_data(tx_data), .tx_en(tx_en),
    .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises one cycle after the tx_en cycle, lasts 10 cycles.
  logic       en_d1;
  logic [3:0] bcnt;
  logic [W-1:0] uart_byte;
  logic       uart_hang;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d1 <= 1'b0; tx_busy <= 1'b0; bcnt <= '0; uart_byte <= '0;
    end else begin
      en_d1 <= tx_en;
      if (tx_en) uart_byte <= tx_data;
      if (en_d1) begin
        tx_busy <= 1'b1; bcnt <= 4'd9;
      end else if (tx_busy && !uart_hang) begin
        if (bcnt == 0) tx_busy <= 1'b0;
        else bcnt <= bcnt - 1'b1;
      end
    end
  end

  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t cur;

  int n_chk = 0;
  int n_fail = 0;
  int launch_cyc = 0;
  int grant_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_launch(input string tag, input bit gap);
    bit seen = 0;
    bit stray = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (tx_en) seen = 1;
      else if (grant != 0) stray = 1;
    end
    chk({tag, "_launch_seen"}, seen, 1);
    chk({tag, "_no_stray_grant"}, stray, 0);
    if (seen && exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      launch_cyc = cyc;
      chk({tag, "_launch_id"}, active_id, cur.id);
      chk({tag, "_launch_data"}, tx_data, cur.data);
      chk({tag, "_launch_busy_nogrant"}, {busy, grant}, {1'b1, 4'b0});
      if (gap) chk({tag, "_idle_gap"}, launch_cyc - grant_cyc, 2);
    end
  endtask

  task automatic wait_grant(input string tag, input int lat, input bit tmo);
    bit seen = 0;
    bit stable = 1;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (grant != 0) seen = 1;
      else if (tx_data !== cur.data || busy !== 1'b1 || tx_en !== 1'b0) stable = 0;
    end
    chk({tag, "_grant_seen"}, seen, 1);
    if (seen) begin
      grant_cyc = cyc;
      chk({tag, "_grant_onehot"}, grant, 4'b0001 << cur.id);
      chk({tag, "_grant_id"}, active_id, cur.id);
      chk({tag, "_grant_tmo_txen"}, {timeout_err, tx_en}, {tmo, 1'b0});
      chk({tag, "_latency"}, grant_cyc - launch_cyc, lat);
      chk({tag, "_uart_byte"}, uart_byte, cur.data);
      chk({tag, "_held_stable"}, stable, 1);
    end
  endtask

  initial begin
    rst = 1'b0; req = '0; req_data = '0; uart_hang = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_outputs", {grant, active_id, busy, tx_data, tx_en, timeout_err}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single requester after reset.
    req = 4'b0001; req_data[7:0] = 8'hA5;
    exp_q.push_back('{2'd0, 8'hA5});
    wait_launch("first", 0);
    wait_grant("first", 13, 0);
    req = 4'b0000;
    @(negedge clk);
    chk("first_idle_after_ack", {busy, grant, tx_en}, '0);

    // Data changed mid-frame is ignored.
    req = 4'b0010; req_data[15:8] = 8'h55;
    exp_q.push_back('{2'd1, 8'h55});
    wait_launch("latch", 0);
    repeat (5) @(negedge clk);
    chk("latch_in_wait_done", {busy, tx_busy}, 2'b11);
    req_data[15:8] = 8'h99;
    wait_grant("latch", 13, 0);
    req = 4'b0000;

    // Reset during WAIT_DONE aborts the byte.
    @(negedge clk);
    req = 4'b0100; req_data[23:16] = 8'h77;
    exp_q.push_back('{2'd2, 8'h77});
    wait_launch("abort", 0);
    repeat (4) @(negedge clk);
    chk("abort_pre_state", {busy, tx_busy}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("abort_reset_outputs", {tx_en, busy, grant}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Round robin from fresh pointer, all requesters active.
    req = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    exp_q.push_back('{2'd0, 8'h10});
    exp_q.push_back('{2'd1, 8'h11});
    exp_q.push_back('{2'd2, 8'h12});
    exp_q.push_back('{2'd3, 8'h13});
    exp_q.push_back('{2'd0, 8'h10});
    wait_launch("rr0", 0);
    wait_grant("rr0", 13, 0);
    wait_launch("rr1", 1);
    wait_grant("rr1", 13, 0);
    wait_launch("rr2", 1);
    wait_grant("rr2", 13, 0);
    wait_launch("rr3", 1);
    wait_grant("rr3", 13, 0);
    wait_launch("rr4", 1);
    wait_grant("rr4", 13, 0);
    req = 4'b0000;

    // Pointer to 2, then 0 is found by wrapping before 1.
    @(negedge clk);
    req = 4'b0100; req_data[23:16] = 8'h22;
    exp_q.push_back('{2'd2, 8'h22});
    wait_launch("wrap_set", 0);
    wait_grant("wrap_set", 13, 0);
    req = 4'b0011; req_data[7:0] = 8'h30; req_data[15:8] = 8'h31;
    exp_q.push_back('{2'd0, 8'h30});
    exp_q.push_back('{2'd1, 8'h31});
    wait_launch("wrap0", 1);
    wait_grant("wrap0", 13, 0);
    req = 4'b0010;
    wait_launch("wrap1", 1);
    wait_grant("wrap1", 13, 0);
    req = 4'b0000;
    @(negedge clk);

    // Hung UART.
    uart_hang = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    req = 4'b1001; req_data[31:24] = 8'hC3; req_data[7:0] = 8'hC0;
    exp_q.push_back('{2'd3, 8'hC3});
    exp_q.push_back('{2'd0, 8'hC0});
    wait_launch("tmo3", 0);
    wait_grant("tmo3", 17, 1);
    req = 4'b0001;
    wait_launch("tmo0", 1);
    wait_grant("tmo0", 17, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("tmo_pulse_one_cycle", {timeout_err, grant}, '0);
`else
    begin
      bit no_grant = 1;
      bit held = 1;
      req = 4'b0001; req_data[7:0] = 8'hD0;
      exp_q.push_back('{2'd0, 8'hD0});
      wait_launch("hang", 0);
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (grant != 0 || timeout_err !== 1'b0) no_grant = 0;
        if (busy !== 1'b1) held = 0;
      end
      chk("hang_no_grant", no_grant, 1);
      chk("hang_busy_held", held, 1);
    end
`endif
    rst = 1'b1;
    req = 4'b0000;
    uart_hang = 1'b0;
    #1 chk("final_reset", {grant, busy, tx_en, timeout_err}, '0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
